// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - state encoding and helper functions for the DIT FFT address controller
package fft_pkg;

    localparam int ST_W = 7;

    // One-hot state codes
    localparam logic [ST_W-1:0] ST_IDLE    = 7'b000_0001;
    localparam logic [ST_W-1:0] ST_CAPTURE = 7'b000_0010;
    localparam logic [ST_W-1:0] ST_RD_TOP  = 7'b000_0100;
    localparam logic [ST_W-1:0] ST_RD_BOT  = 7'b000_1000;
    localparam logic [ST_W-1:0] ST_DRAIN   = 7'b001_0000;
    localparam logic [ST_W-1:0] ST_DONE    = 7'b010_0000;
    localparam logic [ST_W-1:0] ST_WAIT    = 7'b100_0000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_CAPTURE = ST_CAPTURE,
        S_RD_TOP  = ST_RD_TOP,
        S_RD_BOT  = ST_RD_BOT,
        S_DRAIN   = ST_DRAIN,
        S_DONE    = ST_DONE,
        S_WAIT    = ST_WAIT
    } fft_state_t;

    // Bits needed to hold values 0..n-1; never less than one bit so that
    // vectors sized from it stay legal for tiny n.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[5'(w - 1 - i)] = v[5'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// rtl/fft_bf_addr_gen.sv - combinational butterfly operand and twiddle address generator
//
// Ports:
//   stage    - current stage s (0..LOG2N-1)
//   bf_idx   - butterfly index b within the stage (0..N/2-1)
//   top_addr - top operand address  = 2*half*(b div half) + (b mod half)
//   bot_addr - bottom operand address = top_addr + half
//   tw_addr  - twiddle index = (b mod half) << (LOG2N-1-s)
module fft_bf_addr_gen #(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] bf_idx,
    output logic [LOG2N-1:0] top_addr,
    output logic [LOG2N-1:0] bot_addr,
    output logic [LOG2N-2:0] tw_addr
);

    // One extra bit on the stage so that s+1 cannot wrap in the last stage.
    localparam logic [SW:0] ONE      = (SW+1)'(1);
    localparam logic [SW:0] TW_SHIFT = (SW+1)'(LOG2N - 1);

    logic [SW:0]      s_ext;
    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] j;

    assign s_ext = {1'b0, stage};
    assign b_ext = {1'b0, bf_idx};
    assign half  = LOG2N'(1) << s_ext;
    assign j     = b_ext & (half - LOG2N'(1));

    // Group index shifted into place and the in-group offset OR-ed in; bit s
    // of top is always clear, so the bottom address is a plain OR with half.
    assign top_addr = ((b_ext >> s_ext) << (s_ext + ONE)) | j;
    assign bot_addr = top_addr | half;

    // j < 2**s, so the shifted value always fits in LOG2N-1 bits.
    assign tw_addr = (LOG2N-1)'(j << (TW_SHIFT - s_ext));

endmodule

// File: rtl/fft_dit_addr_ctrl.sv
// rtl/fft_dit_addr_ctrl.sv - radix-2 DIT FFT capture and butterfly address controller
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   data_detect         - arms a capture (IDLE only)
//   en_new_count        - returns to IDLE (WAIT only)
//   inv_i               - inverse transform, latched when capture is armed
//   in_valid/in_re/im   - input sample stream
//   wr_en/addr/re/im    - working-RAM write port, bit-reversed address
//   rd_en/rd_addr       - working-RAM read port
//   rd_bot              - 0 top operand, 1 bottom operand
//   tw_en/tw_addr       - twiddle ROM read port
//   tw_conj             - conjugate twiddles (latched inv_i)
//   stage_o             - current stage index
//   busy, done_o        - activity flag and one-cycle completion pulse
//   drop_err            - sticky: sample offered outside capture
//
// Every output is a register loaded from the current state, so all outputs
// trail the state register by exactly one cycle.
module fft_dit_addr_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W = 29,
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_detect,
    input  logic                       en_new_count,
    input  logic                       inv_i,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_re,
    input  logic signed [DATA_W-1:0]   in_im,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr,
    output logic signed [DATA_W-1:0]   wr_re,
    output logic signed [DATA_W-1:0]   wr_im,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr,
    output logic                       rd_bot,
    output logic                       tw_en,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       tw_conj,
    output logic [clog2(LOG2N)-1:0]    stage_o,
    output logic                       busy,
    output logic                       done_o,
    output logic                       drop_err
);

    localparam int N      = 1 << LOG2N;
    localparam int HALF_N = N / 2;
    localparam int SW     = clog2(LOG2N);
    localparam int DW     = clog2(BF_LAT);

    localparam logic [LOG2N-1:0] C_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] B_LAST = (LOG2N-1)'(HALF_N - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);

    fft_state_t state, state_d;

    logic [LOG2N-1:0]          cnt_c, cnt_c_d, c_rev;
    logic [LOG2N-2:0]          bf_b, bf_b_d;
    logic [SW-1:0]             stg_s, stg_s_d;
    logic [DW-1:0]             drn, drn_d;

    logic [LOG2N-1:0]          bg_top, bg_bot;
    logic [LOG2N-2:0]          bg_tw;

    logic                      wr_en_d, rd_en_d, rd_bot_d, tw_en_d;
    logic                      tw_conj_d, busy_d, done_d, drop_d;
    logic [LOG2N-1:0]          wr_addr_d, rd_addr_d;
    logic [LOG2N-2:0]          tw_addr_d;
    logic signed [DATA_W-1:0]  wr_re_d, wr_im_d;
    logic [SW-1:0]             stage_d;

    assign c_rev = LOG2N'(bitrev(32'(cnt_c), LOG2N));

    fft_bf_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .stage    (stg_s),
        .bf_idx   (bf_b),
        .top_addr (bg_top),
        .bot_addr (bg_bot),
        .tw_addr  (bg_tw)
    );

    always_comb begin
        state_d   = state;
        cnt_c_d   = cnt_c;
        bf_b_d    = bf_b;
        stg_s_d   = stg_s;
        drn_d     = drn;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_re_d   = wr_re;
        wr_im_d   = wr_im;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr;
        rd_bot_d  = rd_bot;
        tw_en_d   = 1'b0;
        tw_addr_d = tw_addr;
        tw_conj_d = tw_conj;
        stage_d   = stg_s;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        // A sample offered in any state but CAPTURE is discarded and flagged.
        drop_d    = drop_err | (in_valid && (state != S_CAPTURE));

        unique case (state)
            S_IDLE: begin
                if (data_detect) begin
                    state_d   = S_CAPTURE;
                    tw_conj_d = inv_i;
                    cnt_c_d   = '0;
                    stg_s_d   = '0;
                end
            end
            S_CAPTURE: begin
                busy_d = 1'b1;
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = c_rev;
                    wr_re_d   = in_re;
                    wr_im_d   = in_im;
                    if (cnt_c == C_LAST) begin
                        state_d = S_RD_TOP;
                        cnt_c_d = '0;
                        stg_s_d = '0;
                        bf_b_d  = '0;
                    end else begin
                        cnt_c_d = cnt_c + LOG2N'(1);
                    end
                end
            end
            S_RD_TOP: begin
                busy_d    = 1'b1;
                rd_en_d   = 1'b1;
                rd_bot_d  = 1'b0;
                rd_addr_d = bg_top;
                tw_en_d   = 1'b1;
                tw_addr_d = bg_tw;
                state_d   = S_RD_BOT;
            end
            S_RD_BOT: begin
                busy_d    = 1'b1;
                rd_en_d   = 1'b1;
                rd_bot_d  = 1'b1;
                rd_addr_d = bg_bot;
                if (bf_b == B_LAST) begin
                    state_d = S_DRAIN;
                    drn_d   = '0;
                end else begin
                    bf_b_d  = bf_b + (LOG2N-1)'(1);
                    state_d = S_RD_TOP;
                end
            end
            S_DRAIN: begin
                // Let the last butterfly of the stage write back before the
                // next stage reads its results.
                busy_d = 1'b1;
                if (drn == D_LAST) begin
                    if (stg_s == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        stg_s_d = stg_s + SW'(1);
                        bf_b_d  = '0;
                        state_d = S_RD_TOP;
                    end
                end else begin
                    drn_d = drn + DW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (en_new_count) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt_c    <= '0;
            bf_b     <= '0;
            stg_s    <= '0;
            drn      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_re    <= '0;
            wr_im    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_bot   <= 1'b0;
            tw_en    <= 1'b0;
            tw_addr  <= '0;
            tw_conj  <= 1'b0;
            stage_o  <= '0;
            busy     <= 1'b0;
            done_o   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_d;
            cnt_c    <= cnt_c_d;
            bf_b     <= bf_b_d;
            stg_s    <= stg_s_d;
            drn      <= drn_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_re    <= wr_re_d;
            wr_im    <= wr_im_d;
            rd_en    <= rd_en_d;
            rd_addr  <= rd_addr_d;
            rd_bot   <= rd_bot_d;
            tw_en    <= tw_en_d;
            tw_addr  <= tw_addr_d;
            tw_conj  <= tw_conj_d;
            stage_o  <= stage_d;
            busy     <= busy_d;
            done_o   <= done_d;
            drop_err <= drop_d;
        end
    end

endmodule

// File: tb/tb_fft_dit_addr_ctrl.sv
// tb/tb_fft_dit_addr_ctrl.sv - self-checking bench for fft_dit_addr_ctrl
module tb_fft_dit_addr_ctrl;

    localparam int DATA_W    = 29;
    localparam int LOG2N     = 4;
    localparam int BF_LAT    = 3;
    localparam int N         = 16;
    localparam int SW        = 2;
    localparam int FRAME_CYC = LOG2N * (N + BF_LAT);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     data_detect, en_new_count, inv_i, in_valid;
    logic signed [DATA_W-1:0] in_re, in_im;
    logic                     wr_en, rd_en, rd_bot, tw_en, tw_conj, busy, done_o, drop_err;
    logic [LOG2N-1:0]         wr_addr, rd_addr;
    logic [LOG2N-2:0]         tw_addr;
    logic signed [DATA_W-1:0] wr_re, wr_im;
    logic [SW-1:0]            stage_o;

    always #5 clk = ~clk;

    fft_dit_addr_ctrl #(
        .DATA_W (DATA_W),
        .LOG2N  (LOG2N),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_detect  (data_detect),
        .en_new_count (en_new_count),
        .inv_i        (inv_i),
        .in_valid     (in_valid),
        .in_re        (in_re),
        .in_im        (in_im),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_re        (wr_re),
        .wr_im        (wr_im),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_bot       (rd_bot),
        .tw_en        (tw_en),
        .tw_addr      (tw_addr),
        .tw_conj      (tw_conj),
        .stage_o      (stage_o),
        .busy         (busy),
        .done_o       (done_o),
        .drop_err     (drop_err)
    );

    typedef struct {
        int addr;
        int bot;
        int twen;
        int tw;
        int stg;
        int conj;
    } rd_ev_t;

    rd_ev_t            rd_q[$];
    int                wr_addr_q[$];
    logic [DATA_W-1:0] wr_re_q[$];
    logic [DATA_W-1:0] wr_im_q[$];
    int                wr_cyc_q[$];
    int                gap_q[$];
    int                cyc, first_rd, low_run, done_cnt, done_cyc, tw_stray;
    logic              busy_first_rd;
    int                n_tests, n_fail;
    logic [DATA_W-1:0] smp_re[N];
    logic [DATA_W-1:0] smp_im[N];
    int                iv_cyc[N];
    bit                inv_c;
    int                budget;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bitrev_m(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic clear_mon();
        rd_q.delete();
        wr_addr_q.delete();
        wr_re_q.delete();
        wr_im_q.delete();
        wr_cyc_q.delete();
        gap_q.delete();
        first_rd      = -1;
        low_run       = 0;
        done_cnt      = 0;
        done_cyc      = 0;
        tw_stray      = 0;
        busy_first_rd = 1'b0;
    endtask

    // One clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        rd_ev_t ev;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (wr_en) begin
                wr_addr_q.push_back(int'(wr_addr));
                wr_re_q.push_back(wr_re);
                wr_im_q.push_back(wr_im);
                wr_cyc_q.push_back(cyc);
            end
            if (tw_en && !(rd_en && !rd_bot)) tw_stray++;
            if (rd_en) begin
                if (first_rd >= 0 && low_run > 0) gap_q.push_back(low_run);
                if (first_rd < 0) begin
                    first_rd      = cyc;
                    busy_first_rd = busy;
                end
                low_run  = 0;
                ev.addr  = int'(rd_addr);
                ev.bot   = int'(rd_bot);
                ev.twen  = int'(tw_en);
                ev.tw    = int'(tw_addr);
                ev.stg   = int'(stage_o);
                ev.conj  = int'(tw_conj);
                rd_q.push_back(ev);
            end else if (first_rd >= 0) begin
                low_run++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic rearm();
        en_new_count = 1'b1;
        tick();
        en_new_count = 1'b0;
        tick();
    endtask

    task automatic drive_samples(input int gap_mode);
        int gaps;
        for (int k = 0; k < N; k++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
            repeat (gaps) tick();
            in_re     = smp_re[k];
            in_im     = smp_im[k];
            in_valid  = 1'b1;
            iv_cyc[k] = cyc;
            tick();
            in_valid  = 1'b0;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 every third cycle, 2 random gaps.
    // disturb: extra in_valid after capture, inv_i toggling, en_new_count mid-frame.
    task automatic run_frame(input int gap_mode, input bit inv, input bit fixed_data,
                             input bit disturb, input string tag);
        rd_ev_t exp_q[$];
        rd_ev_t e;
        int     half;
        bit     en_sent;
        for (int k = 0; k < N; k++) begin
            smp_re[k] = fixed_data ? DATA_W'(k) : DATA_W'($urandom);
            smp_im[k] = fixed_data ? DATA_W'(100 + k) : DATA_W'($urandom);
        end
        clear_mon();
        inv_i       = inv;
        data_detect = 1'b1;
        tick();
        data_detect = 1'b0;
        if (disturb) inv_i = ~inv;
        drive_samples(gap_mode);
        if (disturb) begin
            in_re    = DATA_W'($urandom);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        en_sent = 1'b0;
        budget  = FRAME_CYC + 40;
        while (done_cnt == 0 && budget > 0) begin
            if (disturb) inv_i = ~inv_i;
            if (disturb && !en_sent && stage_o == SW'(2)) begin
                en_new_count = 1'b1;
                en_sent      = 1'b1;
            end else begin
                en_new_count = 1'b0;
            end
            tick();
            budget--;
        end
        en_new_count = 1'b0;
        repeat (3) tick();

        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_wait"}, busy, 0);
        check({tag, "_busy_run"}, busy_first_rd, 1);
        check({tag, "_wr_cnt"}, wr_addr_q.size(), N);
        for (int k = 0; k < N && k < wr_addr_q.size(); k++) begin
            check({tag, "_wr_addr"}, wr_addr_q[k], bitrev_m(k));
            check({tag, "_wr_re"}, wr_re_q[k], smp_re[k]);
            check({tag, "_wr_im"}, wr_im_q[k], smp_im[k]);
            check({tag, "_wr_lat"}, wr_cyc_q[k] - iv_cyc[k], 1);
        end

        // Every stage pairs each address with bit s clear against its partner
        // half above it, in ascending order; the twiddle step is N/(2*half).
        for (int s = 0; s < LOG2N; s++) begin
            half = 2 ** s;
            for (int i = 0; i < N; i++) begin
                if ((i / half) % 2 == 0) begin
                    e.addr = i;          e.bot = 0; e.twen = 1;
                    e.tw   = (i % half) * (N / (2 * half));
                    e.stg  = s;          e.conj = int'(inv);
                    exp_q.push_back(e);
                    e.addr = i + half;   e.bot = 1; e.twen = 0;
                    exp_q.push_back(e);
                end
            end
        end
        check({tag, "_rd_cnt"}, rd_q.size(), exp_q.size());
        for (int k = 0; k < rd_q.size() && k < exp_q.size(); k++) begin
            check({tag, "_rd_addr"}, rd_q[k].addr, exp_q[k].addr);
            check({tag, "_rd_ctl"},
                  rd_q[k].stg * 8 + rd_q[k].bot * 4 + rd_q[k].twen * 2 + rd_q[k].conj,
                  exp_q[k].stg * 8 + exp_q[k].bot * 4 + exp_q[k].twen * 2 + exp_q[k].conj);
            if (exp_q[k].bot == 0) check({tag, "_tw_addr"}, rd_q[k].tw, exp_q[k].tw);
        end
        check({tag, "_tw_stray"}, tw_stray, 0);
        check({tag, "_first_rd_lat"}, first_rd - iv_cyc[N-1], 2);
        check({tag, "_done_lat"}, done_cyc - first_rd, FRAME_CYC);
        check({tag, "_gap_cnt"}, gap_q.size(), LOG2N - 1);
        for (int k = 0; k < gap_q.size(); k++) check({tag, "_gap_len"}, gap_q[k], BF_LAT);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        rst_n        = 1'b1;
        data_detect  = 1'b0;
        en_new_count = 1'b0;
        inv_i        = 1'b0;
        in_valid     = 1'b0;
        in_re        = '0;
        in_im        = '0;
        clear_mon();
        #2 rst_n = 1'b0;
        tick();
        check("rst_wr_en",    wr_en,    0);
        check("rst_rd_en",    rd_en,    0);
        check("rst_tw_en",    tw_en,    0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done_o,   0);
        check("rst_drop",     drop_err, 0);
        check("rst_stage",    stage_o,  0);
        check("rst_tw_conj",  tw_conj,  0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_rd_addr",  rd_addr,  0);
        check("rst_tw_addr",  tw_addr,  0);
        check("rst_wr_re",    wr_re,    0);
        rst_n = 1'b1;
        tick();

        run_frame(0, 1'b0, 1'b1, 1'b0, "fa");

        // data_detect is ignored while waiting for re-arm
        clear_mon();
        data_detect = 1'b1;
        repeat (4) tick();
        data_detect = 1'b0;
        check("wait_no_arm_busy", busy, 0);
        check("wait_no_arm_wr", wr_addr_q.size(), 0);
        rearm();
        check("drop_clear", drop_err, 0);

        run_frame(1, 1'b1, 1'b0, 1'b1, "fb");
        check("drop_set", drop_err, 1);
        rearm();

        inv_c = 1'($urandom);
        run_frame(2, inv_c, 1'b0, 1'b0, "fc");
        rearm();

        // Asynchronous reset in the middle of stage 1
        for (int k = 0; k < N; k++) begin
            smp_re[k] = DATA_W'($urandom);
            smp_im[k] = DATA_W'($urandom);
        end
        clear_mon();
        inv_i       = 1'b1;
        data_detect = 1'b1;
        tick();
        data_detect = 1'b0;
        drive_samples(0);
        budget = FRAME_CYC;
        while (stage_o != SW'(1) && budget > 0) begin
            tick();
            budget--;
        end
        check("mid_reach_stage1", stage_o, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en",   rd_en,    0);
        check("mid_rst_tw_en",   tw_en,    0);
        check("mid_rst_busy",    busy,     0);
        check("mid_rst_stage",   stage_o,  0);
        check("mid_rst_tw_conj", tw_conj,  0);
        check("mid_rst_drop",    drop_err, 0);
        check("mid_rst_rd_addr", rd_addr,  0);
        check("mid_rst_wr_addr", wr_addr,  0);
        check("mid_rst_wr_re",   wr_re,    0);
        check("mid_rst_tw_addr", tw_addr,  0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_mon();
        repeat (FRAME_CYC + 20) tick();
        check("mid_no_done", done_cnt, 0);
        check("mid_no_rd", rd_q.size(), 0);
        check("mid_idle_busy", busy, 0);

        run_frame(0, 1'b0, 1'b0, 1'b0, "fd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
